// File: rtl/serial_parity_rx.sv
// ---------------------------------------------------------------------------
// serial_parity_rx
//   UART-style receiver: start bit, DBIT data bits (LSB first), one parity
//   bit, one stop bit. Oversampled at 16x via s_tick. Reports the received
//   byte together with parity and framing error flags once per frame.
//
// Parameters
//   DBIT     data bits per frame (1..8)
//   SB_TICK  oversample ticks spanning the stop bit
//   ODD      parity sense: 0 = even, 1 = odd
//
// Ports
//   clk           in   system clock, rising edge
//   reset_n       in   synchronous active-low reset
//   s_tick        in   one-clk enable at 16x bit rate
//   rx            in   synchronized serial line, idle high
//   dout          out  received data, right-aligned, unused MSBs zero
//   rx_done_tick  out  one-clk pulse when a frame completes
//   parity_err    out  parity check failed on the last frame
//   frame_err     out  stop bit sampled low on the last frame
// ---------------------------------------------------------------------------
module serial_parity_rx #(
    parameter int DBIT    = 8,
    parameter int SB_TICK = 16,
    parameter int ODD     = 0
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       s_tick,
    input  logic       rx,
    output logic [7:0] dout,
    output logic       rx_done_tick,
    output logic       parity_err,
    output logic       frame_err
);

    // Tick counter must reach 15 for data/parity bits and SB_TICK-1 for stop.
    localparam int SW = (SB_TICK > 16) ? $clog2(SB_TICK) : 4;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t        state_q;
    logic [SW-1:0] s_q;
    logic [2:0]    n_q;
    logic [7:0]    shreg_q;
    logic          par_q;
    logic [7:0]    dout_q;
    logic          done_q;
    logic          perr_q;
    logic          ferr_q;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= IDLE;
            s_q     <= '0;
            n_q     <= '0;
            shreg_q <= '0;
            par_q   <= 1'b0;
            dout_q  <= '0;
            done_q  <= 1'b0;
            perr_q  <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                // Start detect does not wait for s_tick so alignment is
                // counted from the first clk the line is seen low.
                IDLE: begin
                    if (!rx) begin
                        state_q <= START;
                        s_q     <= '0;
                        par_q   <= 1'b0;
                    end
                end
                START: begin
                    if (s_tick) begin
                        if (s_q == SW'(7)) begin
                            // Mid-bit: a high line here is a glitch, not a start.
                            if (!rx) begin
                                state_q <= DATA;
                                s_q     <= '0;
                                n_q     <= '0;
                            end else begin
                                state_q <= IDLE;
                            end
                        end else begin
                            s_q <= s_q + SW'(1);
                        end
                    end
                end
                DATA: begin
                    if (s_tick) begin
                        if (s_q == SW'(15)) begin
                            shreg_q <= {rx, shreg_q[7:1]};
                            par_q   <= par_q ^ rx;
                            s_q     <= '0;
                            if (n_q == 3'(DBIT - 1)) state_q <= PARITY;
                            else                     n_q     <= n_q + 3'd1;
                        end else begin
                            s_q <= s_q + SW'(1);
                        end
                    end
                end
                PARITY: begin
                    if (s_tick) begin
                        if (s_q == SW'(15)) begin
                            par_q   <= par_q ^ rx;
                            s_q     <= '0;
                            state_q <= STOP;
                        end else begin
                            s_q <= s_q + SW'(1);
                        end
                    end
                end
                STOP: begin
                    if (s_tick) begin
                        if (s_q == SW'(SB_TICK - 1)) begin
                            done_q  <= 1'b1;
                            // Bits entered at the MSB; shift down when DBIT<8
                            // so the first data bit lands at bit 0.
                            dout_q  <= shreg_q >> (8 - DBIT);
                            perr_q  <= (par_q != 1'(ODD));
                            ferr_q  <= ~rx;
                            state_q <= IDLE;
                        end else begin
                            s_q <= s_q + SW'(1);
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign dout         = dout_q;
    assign rx_done_tick = done_q;
    assign parity_err   = perr_q;
    assign frame_err    = ferr_q;

endmodule

// File: tb/tb_serial_parity_rx.sv
`timescale 1ns/1ps
module tb_serial_parity_rx;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       s_tick;
    logic       rx0, rx1;
    logic [7:0] dout0, dout1;
    logic       done0, done1, perr0, perr1, ferr0, ferr1;

    int nchk  = 0;
    int nfail = 0;
    int cnt0  = 0;
    int cnt1  = 0;

    // dut0: even parity, 8 data bits. dut1: odd parity, 7 data bits.
    serial_parity_rx #(.DBIT(8), .SB_TICK(16), .ODD(0)) dut0 (
        .clk(clk), .reset_n(reset_n), .s_tick(s_tick), .rx(rx0),
        .dout(dout0), .rx_done_tick(done0), .parity_err(perr0), .frame_err(ferr0)
    );
    serial_parity_rx #(.DBIT(7), .SB_TICK(16), .ODD(1)) dut1 (
        .clk(clk), .reset_n(reset_n), .s_tick(s_tick), .rx(rx1),
        .dout(dout1), .rx_done_tick(done1), .parity_err(perr1), .frame_err(ferr1)
    );

    always #5 clk = ~clk;

    // s_tick high on every other rising edge.
    initial begin
        s_tick = 1'b0;
        forever begin
            @(negedge clk);
            s_tick = ~s_tick;
        end
    end

    always @(negedge clk) begin
        if (done0) cnt0++;
        if (done1) cnt1++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail + 1);
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_ticks(input int k);
        for (int i = 0; i < k; i++) begin
            @(posedge clk);
            while (!s_tick) @(posedge clk);
        end
    endtask

    task automatic drive(input bit sel, input bit v);
        @(negedge clk);
        if (sel) rx1 = v;
        else     rx0 = v;
    endtask

    // Whole frame; stop bit held 12 ticks so the done pulse (8 ticks in)
    // lands inside it, then the line idles high.
    task automatic send(input bit sel, input int nb, input logic [7:0] d,
                        input bit pb, input bit sb);
        drive(sel, 1'b0);
        wait_ticks(16);
        for (int i = 0; i < nb; i++) begin
            drive(sel, d[i]);
            wait_ticks(16);
        end
        drive(sel, pb);
        wait_ticks(16);
        drive(sel, sb);
        wait_ticks(12);
        drive(sel, 1'b1);
        wait_ticks(20);
    endtask

    typedef struct {
        bit         sel;
        int         nb;
        logic [7:0] d;
        bit         pb;
        bit         sb;
        logic [7:0] edout;
        bit         eperr;
        bit         eferr;
    } vec_t;

    vec_t vt[8];

    initial begin
        int c0, c1;
        reset_n = 1'b0;
        rx0 = 1'b1;
        rx1 = 1'b1;

        //          sel nb  data   pb sb   dout   pe fe
        vt[0] = '{1'b0, 8, 8'hA5, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b0};
        vt[1] = '{1'b0, 8, 8'h01, 1'b0, 1'b1, 8'h01, 1'b1, 1'b0};
        vt[2] = '{1'b0, 8, 8'h03, 1'b0, 1'b1, 8'h03, 1'b0, 1'b0};
        vt[3] = '{1'b0, 8, 8'h00, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0};
        vt[4] = '{1'b0, 8, 8'h7F, 1'b1, 1'b0, 8'h7F, 1'b0, 1'b1};
        vt[5] = '{1'b1, 7, 8'h55, 1'b1, 1'b1, 8'h55, 1'b0, 1'b0};
        vt[6] = '{1'b1, 7, 8'h55, 1'b0, 1'b1, 8'h55, 1'b1, 1'b0};
        vt[7] = '{1'b1, 7, 8'h7F, 1'b0, 1'b1, 8'h7F, 1'b0, 1'b0};

        repeat (4) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        chk("reset dout0", dout0, 8'h00);
        chk("reset perr0", perr0, 1'b0);
        chk("reset ferr0", ferr0, 1'b0);
        chk("reset done0", done0, 1'b0);
        chk("reset dout1", dout1, 8'h00);
        wait_ticks(4);

        for (int i = 0; i < 8; i++) begin
            c0 = cnt0;
            c1 = cnt1;
            send(vt[i].sel, vt[i].nb, vt[i].d, vt[i].pb, vt[i].sb);
            if (vt[i].sel) begin
                chk($sformatf("vec%0d done", i), cnt1 - c1, 1);
                chk($sformatf("vec%0d dout", i), dout1, vt[i].edout);
                chk($sformatf("vec%0d perr", i), perr1, vt[i].eperr);
                chk($sformatf("vec%0d ferr", i), ferr1, vt[i].eferr);
            end else begin
                chk($sformatf("vec%0d done", i), cnt0 - c0, 1);
                chk($sformatf("vec%0d dout", i), dout0, vt[i].edout);
                chk($sformatf("vec%0d perr", i), perr0, vt[i].eperr);
                chk($sformatf("vec%0d ferr", i), ferr0, vt[i].eferr);
            end
        end

        // Glitch: 5 ticks low is a false start; outputs keep the 0x7F frame.
        c0 = cnt0;
        drive(1'b0, 1'b0);
        wait_ticks(5);
        drive(1'b0, 1'b1);
        wait_ticks(16);
        chk("glitch done", cnt0 - c0, 0);
        chk("glitch dout", dout0, 8'h7F);
        chk("glitch ferr", ferr0, 1'b1);
        chk("glitch perr", perr0, 1'b0);
        send(1'b0, 8, 8'h3C, 1'b0, 1'b1);
        chk("after glitch done", cnt0 - c0, 1);
        chk("after glitch dout", dout0, 8'h3C);
        chk("after glitch ferr", ferr0, 1'b0);

        // Reset mid-frame in the middle of data bit 4.
        c0 = cnt0;
        c1 = cnt1;
        drive(1'b0, 1'b0);
        wait_ticks(16);
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 1'(8'hA5 >> i));
            wait_ticks(16);
        end
        drive(1'b0, 1'b0);
        wait_ticks(8);
        @(negedge clk);
        reset_n = 1'b0;
        rx0     = 1'b1;
        @(negedge clk);
        reset_n = 1'b1;
        chk("rst dout0", dout0, 8'h00);
        chk("rst perr0", perr0, 1'b0);
        chk("rst ferr0", ferr0, 1'b0);
        chk("rst dout1", dout1, 8'h00);
        wait_ticks(200);
        chk("rst no done0", cnt0 - c0, 0);
        chk("rst no done1", cnt1 - c1, 0);
        send(1'b0, 8, 8'hC3, 1'b0, 1'b1);
        chk("after rst done", cnt0 - c0, 1);
        chk("after rst dout", dout0, 8'hC3);
        chk("after rst perr", perr0, 1'b0);
        chk("after rst ferr", ferr0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end

endmodule
